// File: rtl/router_pkg.sv
// router_pkg
//   Shared definitions for the router block: default datapath widths, the
//   reserved (invalid) destination address and the router FSM state encoding
//   that router_fsm uses to drive the *_state strobes of the register stage.
package router_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ADDR_WIDTH_DEF = 2;

   // All-ones address is never routed. This is the default-width form; the
   // register stage builds its own all-ones constant for its ADDR_WIDTH.
   localparam logic [ADDR_WIDTH_DEF-1:0] INVALID_ADDR = '1;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } fsm_state_e;

endpackage

// File: rtl/router_reg_param_if.sv
// router_reg_param_if
//   Bundle between the router FSM/source (master) and the register stage
//   (slave).
//   master drives : pkt_valid, fifo_full, rst_int_reg, detect_add, ld_state,
//                   laf_state, full_state, lfd_state, data_in
//   slave drives  : parity_done, low_pkt_valid, err, len_err, dout
interface router_reg_param_if import router_pkg::*; #(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic                  pkt_valid;
   logic                  fifo_full;
   logic                  rst_int_reg;
   logic                  detect_add;
   logic                  ld_state;
   logic                  laf_state;
   logic                  full_state;
   logic                  lfd_state;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  parity_done;
   logic                  low_pkt_valid;
   logic                  err;
   logic                  len_err;
   logic [DATA_WIDTH-1:0] dout;

   modport master (
      output pkt_valid, fifo_full, rst_int_reg, detect_add, ld_state,
             laf_state, full_state, lfd_state, data_in,
      input  parity_done, low_pkt_valid, err, len_err, dout
   );

   modport slave (
      input  pkt_valid, fifo_full, rst_int_reg, detect_add, ld_state,
             laf_state, full_state, lfd_state, data_in,
      output parity_done, low_pkt_valid, err, len_err, dout
   );
endinterface

// File: rtl/router_par_chk.sv
// router_par_chk
//   Parity / length checker of the register stage. Accumulates XOR parity of
//   header + payload, latches the packet parity word, counts payload words and
//   evaluates err / len_err once per packet.
//   Ports: clock, resetn (sync, active low); clr (header accepted);
//          lfd_en / ld_en (prioritised state strobes from the top);
//          pkt_valid, data_in, hdr, parity_done in; err, len_err out.
module router_par_chk #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2,
   parameter bit LEN_CHECK  = 1'b1
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  clr,
   input  logic                  lfd_en,
   input  logic                  ld_en,
   input  logic                  pkt_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0] hdr,
   input  logic                  parity_done,
   output logic                  err,
   output logic                  len_err
);
   localparam int LEN_WIDTH = DATA_WIDTH - ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] int_par;
   logic [DATA_WIDTH-1:0] pkt_par;
   logic [LEN_WIDTH-1:0]  cnt;
   logic                  pd_q;
   logic                  chk;

   // Evaluate exactly once: the first cycle parity_done is seen high.
   assign chk = parity_done && !pd_q;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         int_par <= '0;
         pkt_par <= '0;
         cnt     <= '0;
         pd_q    <= 1'b0;
         err     <= 1'b0;
         len_err <= 1'b0;
      end else begin
         pd_q <= parity_done;
         if (clr) begin
            int_par <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            len_err <= 1'b0;
         end else begin
            if (lfd_en)
               int_par <= hdr;
            else if (ld_en && pkt_valid) begin
               // Counted on the load edge only; a replay from hold does not recount.
               int_par <= int_par ^ data_in;
               if (cnt != '1)
                  cnt <= cnt + 1'b1;
            end
            if (chk) begin
               err     <= (int_par != pkt_par);
               len_err <= LEN_CHECK && (cnt != hdr[DATA_WIDTH-1:ADDR_WIDTH]);
            end
         end
         if (ld_en && !pkt_valid)
            pkt_par <= data_in;
      end
   end
endmodule

// File: rtl/router_reg_param.sv
// router_reg_param
//   Router datapath register stage between the router FSM and the output
//   FIFOs. Latches the header, forwards words on dout, parks a word in hold
//   while the FIFO is full, and raises parity_done / low_pkt_valid. Parity and
//   length checking live in router_par_chk.
//   Ports: clock, resetn (sync, active low), rif (router_reg_param_if.slave).
//   rif must be instantiated with the same DATA_WIDTH as this module.
module router_reg_param import router_pkg::*; #(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter bit LEN_CHECK  = 1'b1
) (
   input  logic              clock,
   input  logic              resetn,
   router_reg_param_if.slave rif
);
   localparam logic [ADDR_WIDTH-1:0] ADDR_INV = '1;

   logic [DATA_WIDTH-1:0] hdr;
   logic [DATA_WIDTH-1:0] hold;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  low_q;
   logic                  pd_q;
   logic                  hdr_acc;
   logic                  lfd_en;
   logic                  ld_en;
   logic                  laf_en;

   assign hdr_acc = rif.detect_add && rif.pkt_valid &&
                    (rif.data_in[ADDR_WIDTH-1:0] != ADDR_INV);

   // State strobes prioritised lfd > ld > laf; full_state freezes the datapath.
   assign lfd_en = rif.lfd_state && !rif.full_state;
   assign ld_en  = rif.ld_state && !rif.lfd_state && !rif.full_state;
   assign laf_en = rif.laf_state && !rif.ld_state && !rif.lfd_state && !rif.full_state;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         hdr    <= '0;
         hold   <= '0;
         dout_q <= '0;
         low_q  <= 1'b0;
         pd_q   <= 1'b0;
      end else begin
         if (hdr_acc)
            hdr <= rif.data_in;

         if (lfd_en)
            dout_q <= hdr;
         else if (ld_en) begin
            if (!rif.fifo_full)
               dout_q <= rif.data_in;
            else
               hold <= rif.data_in;
         end else if (laf_en)
            dout_q <= hold;

         if (rif.rst_int_reg)
            low_q <= 1'b0;
         else if (ld_en && !rif.pkt_valid)
            low_q <= 1'b1;

         // Parity word either goes straight out, or is replayed from hold
         // in laf_state once the FIFO drains.
         if (hdr_acc)
            pd_q <= 1'b0;
         else if (ld_en && !rif.pkt_valid && !rif.fifo_full)
            pd_q <= 1'b1;
         else if (laf_en && low_q && !pd_q)
            pd_q <= 1'b1;
      end
   end

   router_par_chk #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_CHECK  (LEN_CHECK)
   ) u_par_chk (
      .clock       (clock),
      .resetn      (resetn),
      .clr         (hdr_acc),
      .lfd_en      (lfd_en),
      .ld_en       (ld_en),
      .pkt_valid   (rif.pkt_valid),
      .data_in     (rif.data_in),
      .hdr         (hdr),
      .parity_done (pd_q),
      .err         (rif.err),
      .len_err     (rif.len_err)
   );

   assign rif.dout          = dout_q;
   assign rif.low_pkt_valid = low_q;
   assign rif.parity_done   = pd_q;
endmodule

// File: tb/tb_router_reg_param.sv
// tb_router_reg_param
//   Directed bench for router_reg_param: 8-bit instance with and without the
//   length check, plus a 16-bit / 3-bit-address instance. Forwarded words are
//   pushed to a scoreboard queue when driven and popped when dout updates.
module tb_router_reg_param;
   logic        clock, resetn;
   logic        pv, ff, rir, da, ld, laf, full, lfd, sel;
   logic [15:0] din;
   logic [15:0] o_dout, o_pd, o_lpv, o_err, o_lerr;
   logic [15:0] sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   router_reg_param_if #(.DATA_WIDTH(8))  if8 ();
   router_reg_param_if #(.DATA_WIDTH(8))  if8n ();
   router_reg_param_if #(.DATA_WIDTH(16)) if16 ();

   assign if8.pkt_valid   = pv;   assign if8n.pkt_valid   = pv;   assign if16.pkt_valid   = pv;
   assign if8.fifo_full   = ff;   assign if8n.fifo_full   = ff;   assign if16.fifo_full   = ff;
   assign if8.rst_int_reg = rir;  assign if8n.rst_int_reg = rir;  assign if16.rst_int_reg = rir;
   assign if8.detect_add  = da;   assign if8n.detect_add  = da;   assign if16.detect_add  = da;
   assign if8.ld_state    = ld;   assign if8n.ld_state    = ld;   assign if16.ld_state    = ld;
   assign if8.laf_state   = laf;  assign if8n.laf_state   = laf;  assign if16.laf_state   = laf;
   assign if8.full_state  = full; assign if8n.full_state  = full; assign if16.full_state  = full;
   assign if8.lfd_state   = lfd;  assign if8n.lfd_state   = lfd;  assign if16.lfd_state   = lfd;
   assign if8.data_in     = din[7:0];
   assign if8n.data_in    = din[7:0];
   assign if16.data_in    = din;

   router_reg_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .LEN_CHECK(1'b1)) dut_a (
      .clock(clock), .resetn(resetn), .rif(if8));
   router_reg_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .LEN_CHECK(1'b0)) dut_n (
      .clock(clock), .resetn(resetn), .rif(if8n));
   router_reg_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .LEN_CHECK(1'b1)) dut_w (
      .clock(clock), .resetn(resetn), .rif(if16));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_comb begin
      if (sel) begin
         o_dout = if16.dout;
         o_pd   = 16'(if16.parity_done);
         o_lpv  = 16'(if16.low_pkt_valid);
         o_err  = 16'(if16.err);
         o_lerr = 16'(if16.len_err);
      end else begin
         o_dout = {8'h00, if8.dout};
         o_pd   = 16'(if8.parity_done);
         o_lpv  = 16'(if8.low_pkt_valid);
         o_err  = 16'(if8.err);
         o_lerr = 16'(if8.len_err);
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      pv = 0; ff = 0; rir = 0; da = 0; ld = 0; laf = 0; full = 0; lfd = 0; din = '0;
   endtask

   // One packet through the FSM sequence; full_at = payload index that meets a
   // full FIFO (-1 none), full_par = FIFO full on the parity word.
   task automatic send(input int w, input int aw, input logic [15:0] hdr, input int n,
                       input int full_at, input bit full_par, input logic [15:0] flip,
                       input bit rir_par);
      logic [15:0] mask, par, d, last, pw, exp;
      mask = (w == 16) ? 16'hFFFF : 16'h00FF;
      sel  = (w == 16);
      idle(); da = 1; pv = 1; din = hdr; cyc();
      chk("hdr_err_clr", o_err, 16'd0);
      chk("hdr_len_clr", o_lerr, 16'd0);
      chk("hdr_pd_clr", o_pd, 16'd0);
      idle(); lfd = 1; pv = 1; din = 16'($urandom) & mask;
      sb_q.push_back(hdr); cyc();
      exp = sb_q.pop_front(); chk("lfd_dout", o_dout, exp);
      par = hdr; last = hdr;
      for (int i = 0; i < n; i++) begin
         d = (i == full_at) ? 16'h00A5 : (16'($urandom) & mask);
         par ^= d;
         idle(); ld = 1; pv = 1; din = d;
         if (i == full_at) begin
            ff = 1; cyc(); chk("full_hold", o_dout, last);
            idle(); full = 1; ff = 1; pv = 1; cyc(); chk("fullst_hold", o_dout, last);
            idle(); laf = 1; pv = 1;
         end
         sb_q.push_back(d); cyc();
         exp = sb_q.pop_front(); chk("pay_dout", o_dout, exp);
         last = d;
      end
      pw = (par ^ flip) & mask;
      idle(); ld = 1; pv = 0; din = pw; rir = rir_par;
      if (full_par) begin
         ff = 1; cyc();
         chk("par_full_hold", o_dout, last);
         chk("par_full_pd", o_pd, 16'd0);
         chk("par_full_lpv", o_lpv, 16'd1);
         idle(); full = 1; ff = 1; cyc();
         idle(); laf = 1;
      end
      sb_q.push_back(pw); cyc();
      exp = sb_q.pop_front(); chk("par_dout", o_dout, exp);
      chk("par_done", o_pd, 16'd1);
      chk("lpv_set", o_lpv, 16'(!rir_par));
      idle(); rir = 1; cyc();
      chk("lpv_clr", o_lpv, 16'd0);
      chk("err", o_err, 16'(flip != 16'd0));
      chk("len_err", o_lerr, 16'(n != int'(hdr >> aw)));
      if (w == 8) begin
         chk("nochk_len_err", 16'(if8n.len_err), 16'd0);
         chk("nochk_err", 16'(if8n.err), 16'(flip != 16'd0));
      end
      idle();
   endtask

   initial begin
      sel = 0;
      // Reset with every input active
      resetn = 0; pv = 1; ff = 1; rir = 1; da = 1; ld = 1; laf = 1; full = 1; lfd = 1;
      din = 16'hFFFF;
      cyc();
      chk("rst_dout8", 16'(if8.dout), 16'd0);
      chk("rst_pd8", 16'(if8.parity_done), 16'd0);
      chk("rst_lpv8", 16'(if8.low_pkt_valid), 16'd0);
      chk("rst_err8", 16'(if8.err), 16'd0);
      chk("rst_len8", 16'(if8.len_err), 16'd0);
      chk("rst_doutn", 16'(if8n.dout), 16'd0);
      chk("rst_dout16", if16.dout, 16'd0);
      chk("rst_pd16", 16'(if16.parity_done), 16'd0);
      chk("rst_err16", 16'(if16.err), 16'd0);
      chk("rst_len16", 16'(if16.len_err), 16'd0);
      resetn = 1; idle(); cyc();

      send(8, 2, 16'h0049, 18, -1, 0, 16'h0000, 0);   // good packet
      send(8, 2, 16'h0049, 18, -1, 0, 16'h0001, 0);   // bad parity
      // invalid address: nothing may change, err stays sticky
      idle(); da = 1; pv = 1; din = 16'h00FF; cyc();
      chk("inv_err_hold", o_err, 16'd1);
      chk("inv_pd_hold", o_pd, 16'd1);
      send(8, 2, 16'h0049, 17, -1, 0, 16'h0000, 0);   // length mismatch
      send(8, 2, 16'h0049, 18, 4, 0, 16'h0000, 0);    // full on byte 5
      send(8, 2, 16'h0002, 0, -1, 0, 16'h0000, 0);    // zero-length header
      send(8, 2, 16'h000D, 3, -1, 0, 16'h0000, 1);    // rst_int_reg with set
      send(8, 2, 16'h0049, 18, -1, 1, 16'h0000, 0);   // full on parity

      // reset mid-packet
      sel = 0;
      idle(); da = 1; pv = 1; din = 16'h0049; cyc();
      idle(); lfd = 1; pv = 1; cyc();
      idle(); ld = 1; pv = 1; din = 16'h0011; cyc();
      resetn = 0; din = 16'h0022; cyc();
      chk("mid_rst_dout", o_dout, 16'd0);
      chk("mid_rst_pd", o_pd, 16'd0);
      chk("mid_rst_lpv", o_lpv, 16'd0);
      chk("mid_rst_err", o_err, 16'd0);
      resetn = 1; idle(); cyc();
      send(8, 2, 16'h0049, 18, -1, 0, 16'h0000, 0);

      // 16-bit data / 3-bit address: len 12, addr 2
      send(16, 3, 16'h0062, 12, -1, 1, 16'h0000, 0);
      send(16, 3, 16'h0062, 12, 3, 1, 16'h0100, 0);
      send(16, 3, 16'h0062, 11, -1, 0, 16'h0000, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
